// File: rtl/result_scheduler.sv
// Round-robin scheduler sharing the result write-back master between NUM_SRC FIFO heads,
// with per-set tag transaction insertion. Optional watchdog: define RESULT_SCHED_TIMEOUT_EN.
`ifndef MASTER_DATA_WIDTH
`define MASTER_DATA_WIDTH 32
`endif

module result_scheduler #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned DATA_WIDTH     = `MASTER_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          CGRA_CLK_I,
  input  logic                          RST_I,
  input  logic                          EN_I,
  input  logic                          SET_START_I,
  input  logic [NUM_SRC-1:0]            SRC_REQ_I,
  input  logic [NUM_SRC*8-1:0]          SRC_LEN_I,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] SRC_DATA_I,
  output logic [NUM_SRC-1:0]            SRC_POP_O,
  output logic                          START_TRANSACTION_O,
  output logic                          START_IS_NEW_TRANSACTION_SET_O,
  output logic                          INCREMENT_TARGET_ADDR_O,
  output logic [7:0]                    START_TRANSACTION_LENGTH_O,
  output logic [DATA_WIDTH-1:0]         DATA_TO_SEND_O,
  input  logic                          DATA_TRANSFER_COMPLETED_I,
  input  logic                          WAITING_FOR_ADDR_TRANSFER_I,
  output logic [NUM_SRC-1:0]            GRANT_O,
  output logic                          BUSY_O,
  output logic                          ERROR_O
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned LEN_W = 8;

  if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("result_scheduler: NUM_SRC must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [2:0] {IDLE, INC, TAG_START, TAG_WAIT, ARB, START, DATA, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               set_pending_q, set_active_q, tag_seen_q, burst_done_q;
  logic [PTR_W-1:0]   ptr_q, gidx_q, gnt_idx_c, idx_c;
  logic [NUM_SRC-1:0] grant_q;
  logic [LEN_W-1:0]   len_q, cnt_q, len_sel_c, start_len_c;
  logic               gnt_found_c, beat_c, last_beat_c, inc_entry_c, timeout_c;
  logic               inc_c, start_c, tag_c;
  logic [DATA_WIDTH-1:0] data_c;

  // Cyclic search for the first requester after the round-robin pointer
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    idx_c       = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx_c = PTR_W'((32'(ptr_q) + k) % NUM_SRC);
      if (!gnt_found_c && SRC_REQ_I[idx_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = idx_c;
      end
    end
  end

  always_comb begin
    len_sel_c = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (PTR_W'(k) == gnt_idx_c) len_sel_c = SRC_LEN_I[k*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    data_c = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (grant_q[k]) data_c = SRC_DATA_I[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Beats are counted whatever EN_I says; burst_done_q swallows any beyond len
  assign beat_c      = (state_q == DATA) && DATA_TRANSFER_COMPLETED_I && !burst_done_q;
  assign last_beat_c = beat_c && (cnt_q == len_q);
  assign inc_entry_c = (state_q == IDLE) && (state_d == INC);

  always_ff @(posedge CGRA_CLK_I) begin
    if (RST_I) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    inc_c       = 1'b0;
    start_c     = 1'b0;
    tag_c       = 1'b0;
    start_len_c = '0;
    case (state_q)
      IDLE: begin
        if (EN_I) begin
          if (set_pending_q)                 state_d = INC;
          else if (set_active_q && |SRC_REQ_I) state_d = ARB;
        end
      end
      INC: begin
        if (EN_I) begin
          inc_c   = 1'b1;
          state_d = TAG_START;
        end
      end
      TAG_START: begin
        tag_c = 1'b1;
        if (EN_I) begin
          start_c = 1'b1;
          state_d = TAG_WAIT;
        end
      end
      TAG_WAIT: begin
        tag_c = !tag_seen_q;
        if (EN_I && tag_seen_q && !WAITING_FOR_ADDR_TRANSFER_I) state_d = IDLE;
      end
      ARB: begin
        if (EN_I) state_d = gnt_found_c ? START : IDLE;
      end
      START: begin
        start_len_c = len_q;
        if (EN_I) begin
          start_c = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (EN_I && (burst_done_q || last_beat_c)) state_d = DRAIN;
      end
      DRAIN: begin
        if (EN_I && !WAITING_FOR_ADDR_TRANSFER_I) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout_c) state_d = IDLE;
  end

  always_ff @(posedge CGRA_CLK_I) begin
    if (RST_I) begin
      set_pending_q <= 1'b0;
      set_active_q  <= 1'b0;
      tag_seen_q    <= 1'b0;
      burst_done_q  <= 1'b0;
      ptr_q         <= PTR_W'(NUM_SRC - 1);
      gidx_q        <= '0;
      grant_q       <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
    end else begin
      set_pending_q <= SET_START_I | (set_pending_q & ~inc_entry_c);
      if (state_q == TAG_START)                               tag_seen_q <= 1'b0;
      else if (state_q == TAG_WAIT && DATA_TRANSFER_COMPLETED_I) tag_seen_q <= 1'b1;
      if (state_q == TAG_WAIT && state_d == IDLE && !timeout_c) set_active_q <= 1'b1;
      if (state_q == ARB && state_d == START) begin
        gidx_q       <= gnt_idx_c;
        grant_q      <= NUM_SRC'(1) << gnt_idx_c;
        len_q        <= len_sel_c;
        cnt_q        <= '0;
        burst_done_q <= 1'b0;
      end
      if (beat_c) begin
        cnt_q <= cnt_q + 1'b1;
        if (last_beat_c) burst_done_q <= 1'b1;
      end
      if (state_q == DRAIN && state_d == IDLE) ptr_q <= gidx_q;
      if (state_q != IDLE && state_d == IDLE)  grant_q <= '0;
    end
  end

`ifdef RESULT_SCHED_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr_q;
  logic             error_q, wait_st_c;

  assign wait_st_c = state_q inside {TAG_WAIT, DATA, DRAIN};
  assign timeout_c = wait_st_c && !DATA_TRANSFER_COMPLETED_I &&
                     (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on every completion and every state change
  always_ff @(posedge CGRA_CLK_I) begin
    if (RST_I) begin
      tmr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      if (timeout_c) error_q <= 1'b1;
      if (DATA_TRANSFER_COMPLETED_I || state_d != state_q || !wait_st_c) tmr_q <= '0;
      else                                                               tmr_q <= tmr_q + 1'b1;
    end
  end

  assign ERROR_O = error_q;
`else
  assign timeout_c = 1'b0;
  assign ERROR_O   = 1'b0;
`endif

  assign SRC_POP_O                      = (beat_c && !RST_I) ? grant_q : '0;
  assign START_TRANSACTION_O            = start_c;
  assign START_IS_NEW_TRANSACTION_SET_O = tag_c;
  assign INCREMENT_TARGET_ADDR_O        = inc_c;
  assign START_TRANSACTION_LENGTH_O     = start_len_c;
  assign DATA_TO_SEND_O                 = data_c;
  assign GRANT_O                        = grant_q;
  assign BUSY_O                         = (state_q != IDLE);

endmodule

// File: tb/tb_result_scheduler.sv
// Directed bench for result_scheduler: set/tag sequencing, round-robin bursts, enable hold,
// reset abort and (with RESULT_SCHED_TIMEOUT_EN) the watchdog.
module tb_result_scheduler;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;

  logic           clk = 1'b0;
  logic           rst, en, set_start, compl, waiting;
  logic [NS-1:0]  req;
  logic [NS*8-1:0] len;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]  pop, grant;
  logic           start, marker, inc, busy, error;
  logic [7:0]     start_len;
  logic [DW-1:0]  dts;

  logic [23:0]    head [NS];
  int             served [NS];
  int             inc_total = 0;
  int             n_checks = 0;
  int             n_fail = 0;

  always #5 clk = ~clk;

  result_scheduler #(.NUM_SRC(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .CGRA_CLK_I(clk), .RST_I(rst), .EN_I(en), .SET_START_I(set_start),
    .SRC_REQ_I(req), .SRC_LEN_I(len), .SRC_DATA_I(src_data), .SRC_POP_O(pop),
    .START_TRANSACTION_O(start), .START_IS_NEW_TRANSACTION_SET_O(marker),
    .INCREMENT_TARGET_ADDR_O(inc), .START_TRANSACTION_LENGTH_O(start_len),
    .DATA_TO_SEND_O(dts), .DATA_TRANSFER_COMPLETED_I(compl),
    .WAITING_FOR_ADDR_TRANSFER_I(waiting), .GRANT_O(grant), .BUSY_O(busy), .ERROR_O(error)
  );

  // FWFT source model: head word is {source id, words popped so far}
  always_comb begin
    for (int k = 0; k < NS; k++) src_data[k*DW +: DW] = {8'(k), head[k]};
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) head[k] <= '0;
    end else begin
      for (int k = 0; k < NS; k++) if (pop[k]) head[k] <= head[k] + 24'd1;
    end
    if (inc) inc_total <= inc_total + 1;
  end

  function automatic logic [31:0] exp_data(int k, int v);
    return {8'(k), 24'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 60) begin
      if (start) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; set_start = 1'b0; compl = 1'b0; waiting = 1'b0;
    req = '0; len = {8'd3, 8'd3, 8'd3, 8'd3};
    for (int k = 0; k < NS; k++) served[k] = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({pop, start, marker, inc, start_len, grant, busy, error} !== '0)
      begin $display("FAIL reset_outputs got %h want 0", {pop, start, marker, inc, start_len, grant, busy, error}); n_fail++; end
    n_checks++;
    if (dts !== '0) begin $display("FAIL reset_data got %h want 0", dts); n_fail++; end
  endtask

  task automatic test_no_set();
    int starts = 0;
    req = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      if (start || busy) starts++;
      tick();
    end
    n_checks++;
    if (starts !== 0) begin $display("FAIL no_set_start got %0d active cycles want 0", starts); n_fail++; end
    req = '0;
  endtask

  task automatic test_set_start();
    set_start = 1'b1;
    tick();
    set_start = 1'b0;
    n_checks++;
    if (inc !== 1'b0) begin $display("FAIL set_inc_early got %b want 0", inc); n_fail++; end
    tick();
    n_checks++;
    if (inc !== 1'b1 || busy !== 1'b1) begin $display("FAIL set_inc got inc=%b busy=%b want 1 1", inc, busy); n_fail++; end
    tick();
    n_checks++;
    if ({start, marker, start_len} !== {1'b1, 1'b1, 8'd0})
      begin $display("FAIL tag_start got start=%b marker=%b len=%0d want 1 1 0", start, marker, start_len); n_fail++; end
    waiting = 1'b1;
    tick();
    n_checks++;
    if ({start, marker} !== 2'b01) begin $display("FAIL tag_wait got start=%b marker=%b want 0 1", start, marker); n_fail++; end
    compl = 1'b1;
    tick();
    compl = 1'b0;
    n_checks++;
    if ({marker, busy} !== 2'b01) begin $display("FAIL tag_marker_drop got marker=%b busy=%b want 0 1", marker, busy); n_fail++; end
    waiting = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL tag_done_busy got %b want 0", busy); n_fail++; end
  endtask

  task automatic test_round_robin();
    int n, pops, g;
    bit ok;
    req = 4'b1111;
    len = {8'd3, 8'd3, 8'd3, 8'd3};
    for (int b = 0; b < 5; b++) begin
      g = b % NS;
      wait_start(n, ok);
      n_checks++;
      if (!ok) begin $display("FAIL rr_start burst %0d no start within bound", b); n_fail++; end
      if (b > 0) begin
        n_checks++;
        if (n !== 3) begin $display("FAIL rr_gap burst %0d got %0d idle cycles want 3", b, n); n_fail++; end
      end
      n_checks++;
      if (grant !== 4'(1 << g) || start_len !== 8'd3)
        begin $display("FAIL rr_grant burst %0d got grant=%b len=%0d want %b 3", b, grant, start_len, 4'(1 << g)); n_fail++; end
      tick();
      pops = 0;
      for (int i = 0; i < 4; i++) begin
        compl = 1'b1;
        #1;
        n_checks++;
        if (dts !== exp_data(g, served[g]))
          begin $display("FAIL rr_data src %0d beat %0d got %h want %h", g, i, dts, exp_data(g, served[g])); n_fail++; end
        if (pop === 4'(1 << g)) pops++;
        tick();
        served[g]++;
      end
      compl = 1'b0;
      n_checks++;
      if (pops !== 4) begin $display("FAIL rr_pops src %0d got %0d want 4", g, pops); n_fail++; end
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_set_mid_burst();
    int n, inc_before, pops;
    bit ok;
    req = 4'b1100;
    len = {8'd3, 8'd7, 8'd3, 8'd3};
    inc_before = inc_total;
    wait_start(n, ok);
    n_checks++;
    if (!ok || grant !== 4'b0100 || start_len !== 8'd7)
      begin $display("FAIL mid_grant got ok=%b grant=%b len=%0d want 1 0100 7", ok, grant, start_len); n_fail++; end
    tick();
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      compl = 1'b1;
      set_start = (i == 2 || i == 5);
      #1;
      if (pop === 4'b0100) pops++;
      tick();
      served[2]++;
    end
    compl = 1'b0;
    set_start = 1'b0;
    n_checks++;
    if (pops !== 8) begin $display("FAIL mid_pops got %0d want 8", pops); n_fail++; end
    n = 0;
    while (!inc && n < 20) begin tick(); n++; end
    n_checks++;
    if (!inc || grant !== 4'b0000) begin $display("FAIL mid_inc got inc=%b grant=%b want 1 0000", inc, grant); n_fail++; end
    tick();
    n_checks++;
    if ({start, marker} !== 2'b11) begin $display("FAIL mid_tag got start=%b marker=%b want 1 1", start, marker); n_fail++; end
    tick();
    compl = 1'b1;
    tick();
    compl = 1'b0;
    wait_start(n, ok);
    n_checks++;
    if (!ok || grant !== 4'b1000 || marker !== 1'b0)
      begin $display("FAIL mid_next got ok=%b grant=%b marker=%b want 1 1000 0", ok, grant, marker); n_fail++; end
    n_checks++;
    if (inc_total - inc_before !== 1) begin $display("FAIL mid_inc_count got %0d want 1", inc_total - inc_before); n_fail++; end
    req = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      compl = 1'b1;
      tick();
      served[3]++;
    end
    compl = 1'b0;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL mid_idle busy got %b want 0", busy); n_fail++; end
  endtask

  task automatic test_enable();
    int starts = 0;
    int pops = 0;
    req = 4'b0001;
    tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (start) starts++;
      tick();
    end
    n_checks++;
    if (starts !== 0 || busy !== 1'b1) begin $display("FAIL en_hold got starts=%0d busy=%b want 0 1", starts, busy); n_fail++; end
    en = 1'b1;
    tick();
    n_checks++;
    if (start !== 1'b1 || grant !== 4'b0001) begin $display("FAIL en_start got start=%b grant=%b want 1 0001", start, grant); n_fail++; end
    req = '0;
    tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compl = 1'b1;
      #1;
      if (pop === 4'b0001 && dts === exp_data(0, served[0])) pops++;
      tick();
      served[0]++;
    end
    compl = 1'b0;
    tick();
    n_checks++;
    if (pops !== 4 || busy !== 1'b1) begin $display("FAIL en_pops got %0d busy=%b want 4 1", pops, busy); n_fail++; end
    en = 1'b1;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin $display("FAIL en_done got busy=%b grant=%b want 0 0000", busy, grant); n_fail++; end
  endtask

`ifdef RESULT_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit ok;
    req = 4'b0001;
    wait_start(n, ok);
    req = '0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    n_checks++;
    if (!ok || error !== 1'b0 || busy !== 1'b1)
      begin $display("FAIL to_early got ok=%b error=%b busy=%b want 1 0 1", ok, error, busy); n_fail++; end
    tick();
    n_checks++;
    if ({error, busy, grant} !== {1'b1, 1'b0, 4'b0000})
      begin $display("FAIL to_fire got error=%b busy=%b grant=%b want 1 0 0000", error, busy, grant); n_fail++; end
    tick(); tick();
    n_checks++;
    if (error !== 1'b1) begin $display("FAIL to_sticky got %b want 1", error); n_fail++; end
  endtask
`endif

  task automatic test_reset_mid_burst();
    int n, starts;
    bit ok;
    req = 4'b0010;
    wait_start(n, ok);
    tick();
    compl = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (!ok || pop !== 4'b0000) begin $display("FAIL rst_pop got ok=%b pop=%b want 1 0000", ok, pop); n_fail++; end
    tick();
    rst = 1'b0;
    compl = 1'b0;
    #1;
    n_checks++;
    if ({busy, grant, error} !== 6'b0) begin $display("FAIL rst_abort got busy=%b grant=%b error=%b want 0", busy, grant, error); n_fail++; end
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      if (start) starts++;
      tick();
    end
    n_checks++;
    if (starts !== 0) begin $display("FAIL rst_set_active got %0d starts want 0", starts); n_fail++; end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_no_set();
    test_set_start();
    test_round_robin();
    test_set_mid_burst();
    test_enable();
`ifdef RESULT_SCHED_TIMEOUT_EN
    test_timeout();
`else
    n_checks++;
    if (error !== 1'b0) begin $display("FAIL error_tied got %b want 0", error); n_fail++; end
`endif
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
